mux_scan_seq: RTL and testbench
===============================

# mux_scan_seq

Scan sequencer that sits directly upstream of the 8:1 selector (`sel_8_1`). It drives that selector's `sel` and `n_EN` to walk a programmable range of channels. On each channel it waits a fixed dwell time, then samples the selector output `Y` back. It assembles the samples into an 8-bit captured word and signals frame completion with a one-cycle `done` pulse.

## Interface
- `DWELL`, default 4: cycles spent on each channel before sampling; legal range 1..255.
- `CP` in 1: clock; all state updates on the rising edge.
- `CR` in 1: synchronous, active-high reset.
- `start` in 1: begin a frame; acted on only in IDLE.
- `abort` in 1: terminate a frame early; acted on only in SCAN.
- `dir` in 1: scan direction; 0 = ascending, 1 = descending.
- `first` in 3: first channel of the frame.
- `last` in 3: last channel of the frame.
- `Y` in 1: selector output, fed back from `sel_8_1.Y`.
- `sel` out 3: channel select to `sel_8_1.sel`.
- `n_EN` out 1: active-low selector enable to `sel_8_1.n_EN`.
- `busy` out 1: high while a frame is in progress.
- `ch_valid` out 1: one-cycle pulse each time a channel is sampled.
- `done` out 1: one-cycle pulse when a frame completes normally.
- `Q` out 8: captured word; bit i holds the sample taken from channel i.

## Operation
- Two states: IDLE and SCAN. All outputs are registered.
- Reset: `CR`=1 at an edge forces IDLE and sets `sel`=0, `n_EN`=1, `busy`=0, `ch_valid`=0, `done`=0, `Q`=8'h00 and the dwell counter to 0.
  - `CR` overrides `start`, `abort` and any scan in progress.
- IDLE:
  - `n_EN`=1 and `busy`=0. `sel` and `Q` hold their values.
  - `start`=1 latches `first`, `last` and `dir`, then sets `sel`=`first`, `n_EN`=0, `busy`=1, `Q`=8'h00, dwell counter=0, and enters SCAN.
  - `first`, `last` and `dir` are ignored after the latch point.
- SCAN:
  - The dwell counter increments every cycle.
  - When the counter equals DWELL-1 at an edge:
    - `Q[sel]` takes `Y`, `ch_valid`=1 and the counter returns to 0.
    - If `sel` equals the latched `last`: go to IDLE with `busy`=0, `n_EN`=1 and `done`=1. `sel` holds at `last`.
    - Otherwise `sel` steps by +1 (`dir`=0) or −1 (`dir`=1), modulo 8, so 7→0 and 0→7 wrap.
- Channel count per frame:
  - Ascending: N = ((last − first) mod 8) + 1.
  - Descending: N = ((first − last) mod 8) + 1.
  - `first`=`last` gives N=1. A full 8-channel frame needs last = first−1 (ascending) or first+1 (descending), mod 8.
- `abort`=1 in SCAN:
  - Next edge: IDLE, `busy`=0, `n_EN`=1, dwell counter=0, no `done`.
  - `Q` keeps the bits already sampled.
  - If `abort` coincides with a sample edge, the sample is still written and `ch_valid` fires, but `done` does not.
- `start` while in SCAN is ignored. `start` on the same edge a frame ends is also ignored, because the state is still SCAN at that edge.
- `ch_valid` and `done` are deasserted on every edge where they are not explicitly set.

## Timing
- `start` sampled at edge k: `sel`=`first`, `n_EN`=0 and `busy`=1 are visible after edge k.
- The j-th sample (j = 1..N) is taken at edge k + j·DWELL, using the `Y` present in the cycle before that edge.
  - `ch_valid` is high in the cycle after each sample edge.
  - The `Q` bit updates after the same edge.
- The selector therefore gets DWELL−1 full cycles to settle on each new `sel` before sampling.
- `done` is high for exactly the one cycle after edge k + N·DWELL, coincident with the final `ch_valid`. `busy` falls on the same edge.
- Earliest next `start` is accepted at edge k + N·DWELL + 1.
- Frame length is N·DWELL cycles of `busy`; for N=8 and DWELL=4, that is 32 cycles.
- DWELL=1: one sample per cycle, `ch_valid` held high for N consecutive cycles.

## Test plan
- Reset: hold `CR`=1 for 2 cycles with `start`=1 → `sel`=0, `n_EN`=1, `busy`=0, `ch_valid`=0, `done`=0, `Q`=8'h00, no frame starts.
- Full ascending scan through `sel_8_1`:
  - Stimulus: D=8'hAA, `first`=0, `last`=7, `dir`=0, DWELL=4, `start` at edge k.
  - Required: `sel` 0..7 changing every 4 cycles, 8 `ch_valid` pulses at k+4..k+32, `done` after edge k+32, `Q`=8'hAA, `n_EN`=1 afterwards.
- Descending wrap:
  - Stimulus: D=8'hFF, `first`=1, `last`=6, `dir`=1.
  - Required: `sel` sequence 1,0,7,6; 4 `ch_valid` pulses; `done` after edge k+16; `Q`=8'hC3.
- Single channel:
  - Stimulus: D=8'h20, `first`=`last`=5.
  - Required: one sample, `done` and `ch_valid` together after edge k+4, `Q`=8'h20.
- Abort and re-start:
  - Stimulus: ascending frame 0..7, D=8'h0F; pulse `start` again at k+6; assert `abort` at k+10.
  - Required: second `start` ignored; `busy`=0 and `n_EN`=1 after k+11; no `done`; `Q`=8'h03 (channels 0 and 1 sampled).
- Reset mid-scan: `CR`=1 at k+13 during a frame → all outputs at reset values after k+13; next `start` with `CR`=0 begins a clean frame with `Q` cleared.

Source files
------------

// File: rtl/mux_scan_seq.sv
// mux_scan_seq: walks a programmable channel range on an upstream 8:1
// selector, dwells DWELL cycles per channel, samples the selector output
// back into Q[channel] and pulses done when the frame completes.
module mux_scan_seq #(
    parameter int unsigned DWELL = 4
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       start,
    input  logic       abort,
    input  logic       dir,
    input  logic [2:0] first,
    input  logic [2:0] last,
    input  logic       Y,
    output logic [2:0] sel,
    output logic       n_EN,
    output logic       busy,
    output logic       ch_valid,
    output logic       done,
    output logic [7:0] Q
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    // Counter value at which the current channel is sampled.
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    logic [0:0] state;
    logic [7:0] cnt;
    logic [2:0] last_l;
    logic       dir_l;
    logic       sample;
    logic       at_last;

    assign sample  = (cnt == DWELL_LAST);
    assign at_last = (sel == last_l);

    // Frame latch: range and direction are frozen when a frame is accepted.
    always_ff @(posedge CP) begin
        if (state == S_IDLE && start && !CR) begin
            last_l <= last;
            dir_l  <= dir;
        end
    end

    // Scan state machine, dwell counter, selector drive and capture word.
    always_ff @(posedge CP) begin
        if (CR) begin
            state    <= S_IDLE;
            sel      <= 3'd0;
            n_EN     <= 1'b1;
            busy     <= 1'b0;
            ch_valid <= 1'b0;
            done     <= 1'b0;
            Q        <= 8'h00;
            cnt      <= 8'd0;
        end else begin
            ch_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    n_EN <= 1'b1;
                    busy <= 1'b0;
                    if (start) begin
                        sel   <= first;
                        n_EN  <= 1'b0;
                        busy  <= 1'b1;
                        Q     <= 8'h00;
                        cnt   <= 8'd0;
                        state <= S_SCAN;
                    end
                end
                default: begin
                    if (sample) begin
                        // A sample edge always records the bit, even when aborting.
                        Q[sel]   <= Y;
                        ch_valid <= 1'b1;
                        cnt      <= 8'd0;
                        if (at_last || abort) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            n_EN  <= 1'b1;
                            done  <= at_last && !abort;
                        end else if (dir_l) begin
                            sel <= sel - 3'd1;
                        end else begin
                            sel <= sel + 3'd1;
                        end
                    end else if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        n_EN  <= 1'b1;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_seq.sv
// Testbench for mux_scan_seq: directed frames against a behavioural model of
// the downstream 8:1 selector, with a scoreboard of expected samples.
module tb_mux_scan_seq;

    localparam int DW = 4;

    logic       CP = 1'b0;
    logic       CR;
    logic       start;
    logic       abort;
    logic       dir;
    logic [2:0] first;
    logic [2:0] last;
    logic       Y;
    logic [2:0] sel;
    logic       n_EN;
    logic       busy;
    logic       ch_valid;
    logic       done;
    logic [7:0] Q;

    logic [7:0] D = 8'h00;
    int         cyc = 0;
    int         checks = 0;
    int         passed = 0;

    typedef struct {
        int         at;
        logic [7:0] q;
        logic       dn;
    } exp_t;
    exp_t sb[$];

    mux_scan_seq #(.DWELL(DW)) dut (
        .CP(CP), .CR(CR), .start(start), .abort(abort), .dir(dir),
        .first(first), .last(last), .Y(Y), .sel(sel), .n_EN(n_EN),
        .busy(busy), .ch_valid(ch_valid), .done(done), .Q(Q)
    );

    // Model of sel_8_1: output forced low while disabled.
    assign Y = !n_EN & D[sel];

    always #5 CP = ~CP;

    always @(posedge CP) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected samples: chs holds the hand-listed channel order, 3 bits each, first in LSBs.
    task automatic push_frame(input logic [7:0] d, input logic [23:0] chs, input int n,
                              input int k, input int nsamp, input bit completes);
        logic [7:0] q;
        logic [2:0] ch;
        q = 8'h00;
        for (int j = 0; j < nsamp; j++) begin
            ch = chs[3*j +: 3];
            q[ch] = d[ch];
            sb.push_back('{at: k + (j + 1) * DW, q: q, dn: completes && (j == n - 1)});
        end
    endtask

    // Monitor: every ch_valid/done cycle must match the next scoreboard entry.
    always @(negedge CP) begin
        exp_t e;
        if (ch_valid || done) begin
            if (sb.size() == 0) begin
                chk("unexpected_sample", {30'd0, ch_valid, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sample_cycle", cyc, e.at);
                chk("sample_ch_valid", ch_valid, 1'b1);
                chk("sample_Q", Q, e.q);
                chk("sample_done", done, e.dn);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CP);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge CP);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_sel"}, sel, 3'd0);
        chk({tag, "_n_EN"}, n_EN, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_ch_valid"}, ch_valid, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_Q"}, Q, 8'h00);
    endtask

    // Run a complete frame; called at a negedge with the DUT idle.
    task automatic frame(input string tag, input logic [7:0] d, input logic [2:0] f,
                         input logic [2:0] l, input logic dr, input logic [23:0] chs,
                         input int n, input logic [7:0] qexp);
        int k;
        D = d; first = f; last = l; dir = dr; start = 1'b1;
        k = cyc + 1;
        push_frame(d, chs, n, k, n, 1'b1);
        @(negedge CP);
        start = 1'b0;
        first = ~f; last = ~l; dir = ~dr;
        chk({tag, "_start_sel"}, sel, f);
        chk({tag, "_start_n_EN"}, n_EN, 1'b0);
        chk({tag, "_start_busy"}, busy, 1'b1);
        wait_idle(8 * DW + 4);
        chk({tag, "_end_cycle"}, cyc, k + n * DW);
        chk({tag, "_end_sel"}, sel, l);
        @(negedge CP);
        chk({tag, "_final_Q"}, Q, qexp);
        chk({tag, "_final_n_EN"}, n_EN, 1'b1);
        chk({tag, "_final_busy"}, busy, 1'b0);
    endtask

    initial begin
        int k;
        CR = 1'b1; start = 1'b1; abort = 1'b0; dir = 1'b0; first = 3'd2; last = 3'd4;

        // Reset with start held high.
        tick(2);
        check_reset_state("reset");
        CR = 1'b0; start = 1'b0;
        tick(2);
        chk("reset_no_frame_busy", busy, 1'b0);

        // Full ascending 0..7.
        frame("asc", 8'hAA, 3'd0, 3'd7, 1'b0,
              {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 8, 8'hAA);

        // Descending with wrap: 1,0,7,6.
        frame("desc", 8'hFF, 3'd1, 3'd6, 1'b1,
              {12'd0, 3'd6, 3'd7, 3'd0, 3'd1}, 4, 8'hC3);

        // Single channel.
        frame("single", 8'h20, 3'd5, 3'd5, 1'b0, {21'd0, 3'd5}, 1, 8'h20);

        // Abort with an ignored re-start.
        D = 8'h0F; first = 3'd0; last = 3'd7; dir = 1'b0; start = 1'b1;
        k = cyc + 1;
        push_frame(8'h0F, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 8, k, 2, 1'b0);
        @(negedge CP);
        start = 1'b0;
        tick(5);                        // now after edge k+5
        first = 3'd4; start = 1'b1;     // sampled at edge k+6
        @(negedge CP);
        start = 1'b0;
        chk("abort_restart_ignored_busy", busy, 1'b1);
        tick(4);                        // now after edge k+10
        abort = 1'b1;                   // sampled at edge k+11
        @(negedge CP);
        abort = 1'b0;
        chk("abort_cycle", cyc, k + 11);
        chk("abort_busy", busy, 1'b0);
        chk("abort_n_EN", n_EN, 1'b1);
        tick(2 * DW);
        chk("abort_Q", Q, 8'h03);
        chk("abort_still_idle", busy, 1'b0);

        // Reset in the middle of a frame.
        D = 8'h0F; first = 3'd0; last = 3'd7; dir = 1'b0; start = 1'b1;
        k = cyc + 1;
        push_frame(8'h0F, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 8, k, 3, 1'b0);
        @(negedge CP);
        start = 1'b0;
        for (int i = 0; i < 40 && cyc < k + 12; i++) @(negedge CP);
        CR = 1'b1;                      // sampled at edge k+13
        @(negedge CP);
        chk("midrst_cycle", cyc, k + 13);
        check_reset_state("midrst");
        CR = 1'b0;
        tick(1);
        frame("after_rst", 8'h08, 3'd3, 3'd3, 1'b0, {21'd0, 3'd3}, 1, 8'h08);

        tick(4);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
